// File: rtl/gpu_op_arbiter_pkg.sv
// gpu_op_arbiter_pkg: shared GPU op and arbiter state types
package gpu_op_arbiter_pkg;
  typedef struct packed {
    logic [3:0] cmd;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] w;
    logic [9:0] h;
    logic [7:0] color;
  } gpu_op_t;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t ISSUE   = 2'd1;
  localparam arb_state_t RELEASE = 2'd2;
endpackage

// File: rtl/gpu_op_arbiter_rr_pick.sv
// gpu_op_arbiter_rr_pick: combinational round-robin priority encoder
module gpu_op_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);
  int k;
  // first eligible index strictly after last, wrapping at N
  always_comb begin
    winner = '0;
    valid = 1'b0;
    k = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!valid && eligible[k]) begin
        winner = k[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gpu_op_arbiter.sv
// gpu_op_arbiter: round-robin sharing of the GPU op FIFO write port with per-requester lock
module gpu_op_arbiter
  import gpu_op_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [REQUESTERS-1:0] req,
  input  logic [REQUESTERS-1:0] lock,
  input  gpu_op_t               op_in [REQUESTERS-1:0],
  output logic [REQUESTERS-1:0] ack,
  output gpu_op_t               op,
  output logic                  op_wr_en,
  input  logic                  op_full,
  output logic [IDX_W-1:0]      owner,
  output logic                  status_locked,
  output logic                  status_busy
);
  arb_state_t state;
  logic [REQUESTERS-1:0] ack_q, owner_oh, eligible;
  logic [IDX_W-1:0] last, winner;
  logic wr_q, locked, valid;
  assign owner_oh = REQUESTERS'(1) << owner;
  assign eligible = locked ? (req & owner_oh) : req;
  assign op_wr_en = wr_q & ce;
  assign ack = ack_q & {REQUESTERS{ce}};
  assign status_locked = locked;
  assign status_busy = state != IDLE;
  gpu_op_arbiter_rr_pick #(.N(REQUESTERS), .IDX_W(IDX_W)) u_pick (
    .eligible(eligible),
    .last(last),
    .winner(winner),
    .valid(valid)
  );
  // latch winner in IDLE, write when FIFO has room, one-cycle strobe in RELEASE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      wr_q <= 1'b0;
      ack_q <= '0;
      owner <= '0;
      last <= IDX_W'(REQUESTERS - 1);
      locked <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (valid) begin
            op <= op_in[winner];
            owner <= winner;
            state <= ISSUE;
          end
          if (locked && !req[owner] && !lock[owner]) locked <= 1'b0;
        end
        ISSUE: if (!op_full) begin
          wr_q <= 1'b1;
          ack_q <= owner_oh;
          last <= owner;
          locked <= lock[owner];
          state <= RELEASE;
        end
        RELEASE: begin
          wr_q <= 1'b0;
          ack_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_op_arbiter.sv
// tb_gpu_op_arbiter: directed self-checking bench for gpu_op_arbiter
module tb_gpu_op_arbiter;
  import gpu_op_arbiter_pkg::*;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b1, op_full = 1'b0;
  logic [1:0] req = '0, lock = '0, ack;
  gpu_op_t op_in [1:0];
  gpu_op_t op;
  logic op_wr_en, owner, status_locked, status_busy;
  int checks = 0, failures = 0, wr_cnt = 0, base = 0;
  int wr_x[$];
  logic [1:0] wr_ack[$];
  int done [2];
  gpu_op_arbiter #(.REQUESTERS(2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .req(req), .lock(lock), .op_in(op_in),
    .ack(ack), .op(op), .op_wr_en(op_wr_en), .op_full(op_full), .owner(owner),
    .status_locked(status_locked), .status_busy(status_busy)
  );
  always #5 clk = ~clk;
  // FIFO-side log of every write the DUT makes
  always @(posedge clk) if (op_wr_en) begin
    wr_cnt++;
    wr_x.push_back(int'(op.x));
    wr_ack.push_back(ack);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int i, input int x);
    op_in[i] = '0;
    op_in[i].x = 10'(x);
  endtask
  initial begin
    set_op(0, 0);
    set_op(1, 0);
    step();
    step();
    check("rst_wr_en", 32'(op_wr_en), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_busy", 32'(status_busy), 0);
    check("rst_locked", 32'(status_locked), 0);
    check("rst_op", 32'(op.x), 0);
    rst = 1'b0;
    step();
    base = wr_cnt;
    set_op(0, 20);
    req = 2'b01;
    step();
    check("single_busy", 32'(status_busy), 1);
    check("single_nowr", 32'(op_wr_en), 0);
    check("single_op_latched", 32'(op.x), 20);
    step();
    check("single_wr", 32'(op_wr_en), 1);
    check("single_ack", 32'(ack), 2'b01);
    check("single_op", 32'(op.x), 20);
    req = 2'b00;
    step();
    check("single_wr_clear", 32'(op_wr_en), 0);
    check("single_ack_clear", 32'(ack), 0);
    repeat (5) step();
    check("single_count", 32'(wr_cnt - base), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = wr_cnt;
    set_op(0, 100);
    set_op(1, 200);
    done = '{0, 0};
    req = 2'b11;
    for (int c = 0; c < 60 && req != 2'b00; c++) begin
      step();
      for (int i = 0; i < 2; i++) if (ack[i]) begin
        done[i]++;
        if (done[i] == 3) req[i] = 1'b0;
        else set_op(i, int'(op_in[i].x) + 1);
      end
    end
    check("cont_done", 32'(req), 0);
    step();
    check("cont_count", 32'(wr_cnt - base), 6);
    if (wr_cnt - base == 6)
      for (int j = 0; j < 6; j++) begin
        check($sformatf("cont_ack%0d", j), 32'(wr_ack[base+j]), (j % 2) ? 2 : 1);
        check($sformatf("cont_x%0d", j), 32'(wr_x[base+j]), ((j % 2) ? 200 : 100) + j / 2);
      end
    base = wr_cnt;
    op_full = 1'b1;
    set_op(0, 55);
    req = 2'b01;
    step();
    for (int c = 0; c < 10; c++) begin
      check("bp_nowr", 32'(op_wr_en), 0);
      check("bp_op_stable", 32'(op.x), 55);
      step();
    end
    op_full = 1'b0;
    step();
    check("bp_wr", 32'(op_wr_en), 1);
    check("bp_ack", 32'(ack), 2'b01);
    req = 2'b00;
    step();
    check("bp_wr_once", 32'(op_wr_en), 0);
    repeat (4) step();
    check("bp_count", 32'(wr_cnt - base), 1);
    base = wr_cnt;
    set_op(0, 400);
    set_op(1, 300);
    lock = 2'b10;
    req = 2'b11;
    step();
    check("lock_owner_top", 32'(owner), 1);
    check("lock_op_top", 32'(op.x), 300);
    step();
    check("lock_wr_top", 32'(op_wr_en), 1);
    check("lock_ack_top", 32'(ack), 2'b10);
    set_op(1, 301);
    lock = 2'b00;
    step();
    check("lock_held_a", 32'(status_locked), 1);
    step();
    check("lock_owner_bot", 32'(owner), 1);
    check("lock_op_bot", 32'(op.x), 301);
    check("lock_held_b", 32'(status_locked), 1);
    step();
    check("lock_wr_bot", 32'(op_wr_en), 1);
    check("lock_ack_bot", 32'(ack), 2'b10);
    req = 2'b01;
    step();
    check("lock_released", 32'(status_locked), 0);
    step();
    check("lock_owner_r0", 32'(owner), 0);
    check("lock_op_r0", 32'(op.x), 400);
    step();
    check("lock_wr_r0", 32'(op_wr_en), 1);
    check("lock_ack_r0", 32'(ack), 2'b01);
    req = 2'b00;
    step();
    check("lock_count", 32'(wr_cnt - base), 3);
    base = wr_cnt;
    set_op(0, 500);
    req = 2'b01;
    step();
    step();
    check("ce_wr_on", 32'(op_wr_en), 1);
    req = 2'b00;
    ce = 1'b0;
    #1;
    check("ce_masked", 32'(op_wr_en), 0);
    check("ce_ack_masked", 32'(ack), 0);
    step();
    check("ce_hold_busy", 32'(status_busy), 1);
    check("ce_hold_wr", 32'(op_wr_en), 0);
    step();
    ce = 1'b1;
    #1;
    check("ce_wr_enabled", 32'(op_wr_en), 1);
    step();
    check("ce_wr_done", 32'(op_wr_en), 0);
    check("ce_idle", 32'(status_busy), 0);
    check("ce_count", 32'(wr_cnt - base), 1);
    base = wr_cnt;
    op_full = 1'b1;
    set_op(1, 600);
    req = 2'b10;
    step();
    step();
    check("rst_pre_owner", 32'(owner), 1);
    check("rst_pre_busy", 32'(status_busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_wr_en", 32'(op_wr_en), 0);
    check("mrst_ack", 32'(ack), 0);
    check("mrst_owner", 32'(owner), 0);
    check("mrst_busy", 32'(status_busy), 0);
    check("mrst_op", 32'(op.x), 0);
    req = 2'b00;
    step();
    rst = 1'b0;
    op_full = 1'b0;
    repeat (6) step();
    check("mrst_no_write", 32'(wr_cnt - base), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
